// File: rtl/data_bus_port_pkg.sv
// Types and constants shared by the data-side and fetch-side bus ports.
package data_bus_port_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_WAIT = 2'd2,
        BUS_DONE = 2'd3
    } bus_state_t;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

endpackage

// File: rtl/data_bus_port_load_align.sv
// Shifts the addressed byte/half/word of a bus read down to bit 0 and extends it.
module load_align
    import data_bus_port_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        result  = shifted;
        case (size)
            SIZE_BYTE: result = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: result = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default:   result = shifted;
        endcase
    end

endmodule

// File: rtl/data_bus_port.sv
// Memory-stage data port: runs one load/store at a time on the external valid/ready bus.
module data_bus_port
    import data_bus_port_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_store_data,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic        mem_load,
    input  logic        mem_store,
    output logic [31:0] mem_load_data,
    input  logic        stage_advance,
    output logic        mem_busy,
    output logic        ext_valid,
    input  logic        ext_ready,
    output logic [31:0] ext_address,
    output logic        ext_write,
    output logic [31:0] ext_write_data,
    output logic [3:0]  ext_write_strobe,
    input  logic        ext_rvalid,
    input  logic [31:0] ext_rdata
);

    // Handshake: a request transfers on a rising edge where ext_valid && ext_ready;
    // ext_valid and all request fields are held stable until that edge. The response
    // is the single cycle with ext_rvalid high while in BUS_WAIT.

    bus_state_t  state, state_next;
    logic        req;
    logic        valid_next;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] lane_data;
    logic [3:0]  lane_strobe;
    logic [31:0] load_fmt;

    assign req = (mem_load | mem_store) & (mem_size != SIZE_ILLEGAL);

    always_comb begin
        lane_data   = mem_store_data;
        lane_strobe = 4'b1111;
        case (mem_size)
            SIZE_BYTE: begin
                lane_data   = {4{mem_store_data[7:0]}};
                lane_strobe = 4'b0001 << mem_address[1:0];
            end
            SIZE_HALF: begin
                lane_data   = {2{mem_store_data[15:0]}};
                lane_strobe = 4'b0011 << {mem_address[1], 1'b0};
            end
            default: begin
                lane_data   = mem_store_data;
                lane_strobe = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= BUS_IDLE;
        else       state <= state_next;
    end

    // DONE waits for the stage to capture so a still-held request is not reissued.
    always_comb begin
        state_next = state;
        case (state)
            BUS_IDLE: if (req)           state_next = BUS_REQ;
            BUS_REQ:  if (ext_ready)     state_next = BUS_WAIT;
            BUS_WAIT: if (ext_rvalid)    state_next = BUS_DONE;
            BUS_DONE: if (stage_advance) state_next = BUS_IDLE;
            default:                     state_next = BUS_IDLE;
        endcase
    end

    always_comb begin
        mem_busy   = 1'b0;
        valid_next = 1'b0;
        case (state)
            BUS_IDLE: begin
                mem_busy   = req;
                valid_next = req;
            end
            BUS_REQ: begin
                mem_busy   = 1'b1;
                valid_next = ~ext_ready;
            end
            BUS_WAIT: mem_busy = 1'b1;
            default: begin
                mem_busy   = 1'b0;
                valid_next = 1'b0;
            end
        endcase
    end

    load_align u_load_align (
        .rdata     (ext_rdata),
        .offset    (off_q),
        .size      (size_q),
        .is_signed (signed_q),
        .result    (load_fmt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_valid        <= 1'b0;
            ext_address      <= 32'd0;
            ext_write        <= 1'b0;
            ext_write_data   <= 32'd0;
            ext_write_strobe <= 4'd0;
            off_q            <= 2'd0;
            size_q           <= SIZE_BYTE;
            signed_q         <= 1'b0;
            mem_load_data    <= 32'd0;
        end else begin
            ext_valid <= valid_next;
            if (state == BUS_IDLE && req) begin
                ext_address      <= {mem_address[31:2], 2'b00};
                ext_write        <= mem_store;
                ext_write_data   <= lane_data;
                ext_write_strobe <= mem_store ? lane_strobe : 4'b0000;
                off_q            <= mem_address[1:0];
                size_q           <= mem_size;
                signed_q         <= mem_signed;
            end
            if (state == BUS_WAIT && ext_rvalid && !ext_write)
                mem_load_data <= load_fmt;
        end
    end

endmodule

// File: tb/tb_data_bus_port.sv
// Scoreboard bench for data_bus_port: bus requests and load results checked against a model.
module tb_data_bus_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_address, mem_store_data, mem_load_data;
    logic [1:0]  mem_size;
    logic        mem_signed, mem_load, mem_store, stage_advance, mem_busy;
    logic        ext_valid, ext_ready, ext_write, ext_rvalid;
    logic [31:0] ext_address, ext_write_data, ext_rdata;
    logic [3:0]  ext_write_strobe;

    // Expected request: {write, strobe, address, write_data}
    logic [68:0] exp_q[$];
    logic [31:0] exp_load_q[$];

    int n_checks = 0;
    int n_errors = 0;

    data_bus_port dut (
        .clk(clk), .reset(reset),
        .mem_address(mem_address), .mem_store_data(mem_store_data),
        .mem_size(mem_size), .mem_signed(mem_signed),
        .mem_load(mem_load), .mem_store(mem_store),
        .mem_load_data(mem_load_data), .stage_advance(stage_advance),
        .mem_busy(mem_busy), .ext_valid(ext_valid), .ext_ready(ext_ready),
        .ext_address(ext_address), .ext_write(ext_write),
        .ext_write_data(ext_write_data), .ext_write_strobe(ext_write_strobe),
        .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_strobe(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] s;
        s = 4'b0000;
        if (sz == 2'b00)      s[off] = 1'b1;
        else if (sz == 2'b01) s = off[1] ? 4'b1100 : 4'b0011;
        else                  s = 4'b1111;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (sz == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sgn);
        logic [7:0]  b[4];
        logic [31:0] v;
        for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
        if (sz == 2'b00) begin
            v = {24'd0, b[off]};
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = {16'd0, b[off + 2'd1], b[off]};
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  {31'd0, ext_valid}, 32'd0);
        check({tag, "_write"},  {31'd0, ext_write}, 32'd0);
        check({tag, "_strobe"}, {28'd0, ext_write_strobe}, 32'd0);
        check({tag, "_addr"},   ext_address, 32'd0);
        check({tag, "_wdata"},  ext_write_data, 32'd0);
        check({tag, "_ldata"},  mem_load_data, 32'd0);
        check({tag, "_busy"},   {31'd0, mem_busy}, 32'd0);
    endtask

    // Drives one access from a negedge; cycle 0 is the first cycle the request is visible.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [1:0] sz, input logic sgn, input logic ld,
                           input logic st, input int ready_lat, input int rv_lat,
                           input logic [31:0] rdata, input int hold_done);
        int phase, acc_c, exp_done;
        logic [68:0] e;
        logic        is_wr;
        is_wr    = st;
        exp_done = 3 + ready_lat + rv_lat;
        exp_q.push_back({is_wr, is_wr ? m_strobe(sz, addr[1:0]) : 4'b0000,
                         {addr[31:2], 2'b00}, m_wdata(sz, sdata)});
        if (!is_wr) exp_load_q.push_back(m_load(rdata, addr[1:0], sz, sgn));

        @(negedge clk);
        mem_address = addr; mem_store_data = sdata; mem_size = sz; mem_signed = sgn;
        mem_load = ld; mem_store = st; stage_advance = 1'b0;
        ext_ready = 1'b0; ext_rvalid = 1'b0;
        #1;
        check({tag, "_busy_c0"}, {31'd0, mem_busy}, 32'd1);
        check({tag, "_valid_c0"}, {31'd0, ext_valid}, 32'd0);

        phase = 0;
        acc_c = 0;
        for (int c = 1; c < 60 && phase < 2; c++) begin
            @(negedge clk);
            if (phase == 0) begin
                check({tag, "_busy_req"}, {31'd0, mem_busy}, 32'd1);
                check({tag, "_valid_req"}, {31'd0, ext_valid}, 32'd1);
                e = exp_q[0];
                check({tag, "_addr"}, ext_address, e[63:32]);
                check({tag, "_write"}, {31'd0, ext_write}, {31'd0, e[68]});
                check({tag, "_strobe"}, {28'd0, ext_write_strobe}, {28'd0, e[67:64]});
                if (e[68]) check({tag, "_wdata"}, ext_write_data, e[31:0]);
                ext_rvalid = 1'($urandom_range(0, 1));
                ext_rdata  = $urandom;
                if (c - 1 >= ready_lat) begin
                    ext_ready = 1'b1;
                    void'(exp_q.pop_front());
                    acc_c = c;
                    phase = 1;
                end
            end else begin
                ext_ready = 1'($urandom_range(0, 1));
                check({tag, "_busy_wait"}, {31'd0, mem_busy}, 32'd1);
                check({tag, "_valid_wait"}, {31'd0, ext_valid}, 32'd0);
                if (c >= acc_c + 1 + rv_lat) begin
                    ext_rvalid = 1'b1;
                    ext_rdata  = rdata;
                    phase = 2;
                end else begin
                    ext_rvalid = 1'b0;
                    ext_rdata  = $urandom;
                end
            end
        end

        @(negedge clk);
        ext_rvalid = 1'($urandom_range(0, 1));
        ext_ready  = 1'($urandom_range(0, 1));
        ext_rdata  = $urandom;
        check({tag, "_reached_done"}, phase, 2);
        check({tag, "_done_cycle"}, acc_c + 1 + rv_lat + 1, exp_done);
        check({tag, "_busy_done"}, {31'd0, mem_busy}, 32'd0);
        if (!is_wr && exp_load_q.size() > 0)
            check({tag, "_load_data"}, mem_load_data, exp_load_q.pop_front());
        stage_advance = (hold_done == 0);
        for (int k = 0; k < hold_done; k++) begin
            @(negedge clk);
            check({tag, "_busy_hold"}, {31'd0, mem_busy}, 32'd0);
            check({tag, "_valid_hold"}, {31'd0, ext_valid}, 32'd0);
            stage_advance = (k == hold_done - 1);
        end

        // Back in IDLE with the request still held: busy returns, then the stage drops it.
        @(negedge clk);
        check({tag, "_busy_idle"}, {31'd0, mem_busy}, 32'd1);
        mem_load = 1'b0; mem_store = 1'b0; stage_advance = 1'b0;
        ext_rvalid = 1'b0; ext_ready = 1'b0;
        #1;
        check({tag, "_busy_clear"}, {31'd0, mem_busy}, 32'd0);
        @(negedge clk);
        check({tag, "_no_reissue"}, {31'd0, ext_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, d, rd;
        logic [1:0]  sz;
        logic        ld, st;

        reset = 1'b1;
        mem_address = '0; mem_store_data = '0; mem_size = '0; mem_signed = 1'b0;
        mem_load = 1'b0; mem_store = 1'b0; stage_advance = 1'b0;
        ext_ready = 1'b0; ext_rvalid = 1'b0; ext_rdata = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        run_txn("byte_ld_s", 32'h0000_1003, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0, 0, 0,
                32'h80FF_7F01, 0);
        run_txn("half_st", 32'h0000_2002, 32'h0000_BEEF, 2'b01, 1'b0, 1'b0, 1'b1, 0, 0,
                32'h0, 0);
        run_txn("backpress", 32'h0000_3000, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0, 2, 1,
                32'hCAFE_F00D, 0);
        run_txn("no_reissue", 32'h0000_5001, 32'h0000_00A5, 2'b00, 1'b0, 1'b0, 1'b1, 0, 0,
                32'h0, 4);
        run_txn("half_ld_u", 32'h0000_4002, 32'h0, 2'b01, 1'b0, 1'b1, 1'b0, 0, 0,
                32'h8001_0000, 0);
        run_txn("ld_and_st", 32'h0000_6003, 32'h1234_5677, 2'b00, 1'b0, 1'b1, 1'b1, 1, 0,
                32'h0, 1);

        for (int i = 0; i < 8; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = $urandom;
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
            d  = $urandom;
            rd = $urandom;
            st = 1'($urandom_range(0, 1));
            ld = ~st | 1'($urandom_range(0, 1));
            run_txn("random", a, d, sz, 1'($urandom_range(0, 1)), ld, st,
                    $urandom_range(0, 3), $urandom_range(0, 3), rd,
                    $urandom_range(0, 2));
        end

        // Reset while WAITing; the late response must be ignored.
        @(negedge clk);
        mem_address = 32'h0000_7004; mem_size = 2'b10; mem_load = 1'b1; mem_signed = 1'b0;
        @(negedge clk);
        ext_ready = 1'b1;
        @(negedge clk);
        ext_ready = 1'b0;
        check("rst_mid_busy_wait", {31'd0, mem_busy}, 32'd1);
        reset = 1'b1; mem_load = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        reset = 1'b0; ext_rvalid = 1'b1; ext_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        ext_rvalid = 1'b0;
        check_reset_outputs("rst_stray");
        repeat (2) @(negedge clk);
        check("rst_stray_ldata", mem_load_data, 32'd0);
        check("rst_stray_valid", {31'd0, ext_valid}, 32'd0);

        // Illegal size is not a request.
        mem_size = 2'b11; mem_load = 1'b1; mem_address = 32'h0000_8000;
        #1;
        check("illegal_busy_c0", {31'd0, mem_busy}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("illegal_busy", {31'd0, mem_busy}, 32'd0);
            check("illegal_valid", {31'd0, ext_valid}, 32'd0);
        end
        mem_load = 1'b0; mem_size = 2'b00;

        check("exp_q_empty", exp_q.size(), 0);
        check("exp_load_q_empty", exp_load_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
